// File: rtl/seg7_capture_decoder.sv
// Samples an asynchronous active-low seven-segment bus, debounces it and
// reports each newly stable pattern as a hex digit through a valid/ready hold.
module seg7_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       code_err,
  output logic       blank,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam logic [6:0] BLANK_PAT  = 7'h7F;
  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {TRACK, HOLD} state_t;

  state_t     state_reg, state_next;
  logic [6:0] sync1_reg, seg_s_reg, last_reg;
  logic [7:0] stable_cnt_reg;
  logic [3:0] digit_reg;
  logic       err_reg, blank_reg, overrun_reg;

  logic [15:0] glyph_hit;
  logic [3:0]  glyph_val;
  logic        is_glyph, accept, reportable, load_report, ovr_set;

  // The counter looks ahead at the first stage, so it reads 0 in exactly
  // the cycle where seg_s differs from its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= BLANK_PAT;
      seg_s_reg      <= BLANK_PAT;
      stable_cnt_reg <= '0;
    end else begin
      sync1_reg <= seg;
      seg_s_reg <= sync1_reg;
      if (sync1_reg != seg_s_reg)
        stable_cnt_reg <= '0;
      else if (stable_cnt_reg != 8'hFF)
        stable_cnt_reg <= stable_cnt_reg + 8'd1;
    end
  end

  assign accept     = (stable_cnt_reg == ACCEPT_CNT);
  assign reportable = accept && (seg_s_reg != last_reg) && (seg_s_reg != BLANK_PAT);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_glyph
      assign glyph_hit[gi] = (seg_s_reg == GLYPH[gi]);
    end
  endgenerate

  always_comb begin
    glyph_val = '0;
    for (int i = 0; i < 16; i++)
      if (glyph_hit[i]) glyph_val = 4'(i);
  end
  assign is_glyph = |glyph_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= TRACK;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    load_report = 1'b0;
    ovr_set     = 1'b0;
    case (state_reg)
      TRACK: begin
        if (reportable) begin
          load_report = 1'b1;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (reportable) begin
          // A new report replaces the held one; only an unconsumed one is lost.
          load_report = 1'b1;
          ovr_set     = !digit_ready;
        end else if (digit_ready) begin
          state_next = TRACK;
        end
      end
      default: state_next = TRACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg    <= BLANK_PAT;
      digit_reg   <= '0;
      err_reg     <= 1'b0;
      blank_reg   <= 1'b1;
      overrun_reg <= 1'b0;
    end else begin
      if (accept) begin
        last_reg  <= seg_s_reg;
        blank_reg <= (seg_s_reg == BLANK_PAT);
      end
      if (load_report) begin
        digit_reg <= is_glyph ? glyph_val : 4'h0;
        err_reg   <= !is_glyph;
      end
      if (ovr_set)          overrun_reg <= 1'b1;
      else if (clr_overrun) overrun_reg <= 1'b0;
    end
  end

  assign digit       = digit_reg;
  assign code_err    = err_reg;
  assign digit_valid = (state_reg == HOLD);
  assign blank       = blank_reg;
  assign overrun     = overrun_reg;

endmodule
